// File: rtl/stream_merge_arbiter.sv
// Two-into-one round-robin merge of EOS-terminated streams with start/done control tokens.
// Output is a single register stage; the two input EOS markers collapse into one output EOS.
module stream_merge_arbiter #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inCtrl_valid,
    output logic                   inCtrl_ready,
    input  logic                   in0_valid,
    output logic                   in0_ready,
    input  logic [DATA_WIDTH-1:0]  in0_data_field0,
    input  logic                   in0_data_field1,
    input  logic                   in1_valid,
    output logic                   in1_ready,
    input  logic [DATA_WIDTH-1:0]  in1_data_field0,
    input  logic                   in1_data_field1,
    output logic                   out0_valid,
    input  logic                   out0_ready,
    output logic [DATA_WIDTH-1:0]  out0_data_field0,
    output logic                   out0_data_field1,
    output logic                   out0_src,
    output logic                   outCtrl_valid,
    input  logic                   outCtrl_ready,
    output logic [COUNT_WIDTH-1:0] elem_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_CTRL  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic                   done0_q, done0_d;
    logic                   done1_q, done1_d;
    logic                   last_q, last_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_eos_q, out_eos_d;
    logic                   out_src_q, out_src_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic                  cand0, cand1, grant_any, grant, load_en, xfer, sel_eos;
    logic [DATA_WIDTH-1:0] sel_data;

    always_comb begin
        cand0     = in0_valid && !done0_q;
        cand1     = in1_valid && !done1_q;
        grant_any = cand0 || cand1;
        // last_q holds the previously granted input; on contention the other one wins.
        grant     = (cand0 && cand1) ? ~last_q : cand1;
        load_en   = !out_valid_q || out0_ready;
        xfer      = (state_q == ST_RUN) && grant_any && load_en;
        sel_eos   = grant ? in1_data_field1 : in0_data_field1;
        sel_data  = grant ? in1_data_field0 : in0_data_field0;
    end

    assign in0_ready        = xfer && !grant;
    assign in1_ready        = xfer && grant;
    assign inCtrl_ready     = (state_q == ST_IDLE);
    assign outCtrl_valid    = (state_q == ST_CTRL) && !out_valid_q;
    assign out0_valid       = out_valid_q;
    assign out0_data_field0 = out_data_q;
    assign out0_data_field1 = out_eos_q;
    assign out0_src         = out_src_q;
    assign elem_count       = count_q;

    always_comb begin
        state_d     = state_q;
        done0_d     = done0_q;
        done1_d     = done1_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_eos_d   = out_eos_q;
        out_src_d   = out_src_q;
        count_d     = count_q;

        if (out_valid_q && out0_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (inCtrl_valid) begin
                    state_d = ST_RUN;
                    done0_d = 1'b0;
                    done1_d = 1'b0;
                    count_d = '0;
                    last_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    last_d = grant;
                    if (sel_eos) begin
                        if (grant) begin
                            done1_d = 1'b1;
                        end else begin
                            done0_d = 1'b1;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = sel_data;
                        out_eos_d   = 1'b0;
                        out_src_d   = grant;
                        count_d     = count_q + COUNT_WIDTH'(1);
                    end
                end
                if (done0_d && done1_d) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (load_en) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_eos_d   = 1'b1;
                    out_src_d   = 1'b0;
                    state_d     = ST_CTRL;
                end
            end
            ST_CTRL: begin
                if (outCtrl_valid && outCtrl_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            last_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_eos_q   <= 1'b0;
            out_src_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_eos_q   <= out_eos_d;
            out_src_q   <= out_src_d;
            count_q     <= count_d;
        end
    end

endmodule
